param_update_sequencer: RTL and testbench
=========================================

Name: param_update_sequencer

Overview:
- Sequences host parameter writes (trigger vector plus 32-bit word) into the simulation parameter bank: BDAMP_x, gamma_dyn/sta, pps coefficients, MN gain, gain.
- Writes are buffered in a small FIFO and applied only at a simulation-tick boundary, one per clock. The spindle, MN pool and muscle datapaths therefore never see a parameter change mid-step.
- Sits between the host trigger/wire endpoints and the parameter register bank, in the clk1 domain.

Parameters:
- DEPTH, 8, FIFO entries (power of two, >=2)
- NUM_PARAMS, 16, number of trigger lines / parameter addresses
- ADDR_W, 4, log2(NUM_PARAMS)
- CNT_W, 4, log2(DEPTH)+1

Ports:
- clk  in  1  system clock (clk1)
- reset  in  1  asynchronous, active-high; clears all state
- trig  in  NUM_PARAMS  host trigger vector; each bit is a one-cycle pulse in the clk domain
- wr_data  in  32  value to write, {ep02wire, ep01wire}; valid in the cycle trig is nonzero
- tick  in  1  one-cycle strobe marking the start of a simulation step
- clear_err  in  1  synchronous clear of the sticky error flags
- param_we  out  1  parameter-bank write strobe
- param_addr  out  ADDR_W  parameter index
- param_data  out  32  parameter value
- pending  out  CNT_W  current FIFO occupancy
- busy  out  1  high while state is APPLY
- applied  out  1  one-cycle pulse after a batch completes
- overflow  out  1  sticky: a write was dropped because the FIFO was full
- collision  out  1  sticky: more than one trig bit was set in one cycle

Behaviour:
- Reset values:
  - all outputs 0; FIFO empty; state IDLE.
  - Reset asserted mid-APPLY deasserts param_we immediately, discards queued entries and emits no applied pulse.
- Capture, every cycle with trig != 0:
  - idx = index of the lowest set bit.
  - Push {idx, wr_data} into the FIFO.
  - If popcount(trig) > 1, set collision; the higher bits are dropped.
  - If the FIFO is full, do not push and set overflow; existing entries are untouched.
- Simultaneous push and pop in the same cycle is legal: occupancy is unchanged and the FIFO accepts the push even when full-before-pop.
- FSM states: IDLE, APPLY, DONE.
  - IDLE: on tick with pending != 0, snapshot batch = pending (value before this cycle's push) and go to APPLY. A tick with pending == 0 is ignored.
  - APPLY: each cycle pop the head and drive param_we = 1 with param_addr/param_data registered from that entry; decrement batch. When batch reaches 0, go to DONE.
  - DONE: applied = 1 for one cycle, then return to IDLE.
- Latency:
  - tick sampled at edge T gives param_we high in cycles T+1 .. T+N (N = batch), in FIFO order.
  - applied is high in cycle T+N+1.
- Entries pushed during APPLY or DONE are not in the current batch; they wait for the next tick.
- tick during APPLY or DONE is ignored; it is not queued.
- Multiple writes to the same idx within one batch are all issued in order, so the last one wins in the bank.
- param_addr/param_data hold their last values when param_we = 0.
- busy = (state == APPLY).
- clear_err clears overflow and collision. If an error event occurs in the same cycle as clear_err, the flag ends set (set wins).
- FIFO pointers wrap modulo DEPTH. pending ranges 0..DEPTH.

Test Plan:
1. Single write and apply: trig=16'h0008, wr_data=32'h42A0_0000, then tick 5 cycles later -> one param_we cycle, addr=3, data=42A0_0000, at tick+1; applied at tick+2; pending returns to 0.
2. Batch ordering: pulse trig bits 15, 14, 13 with 3E71_4120, 3D14_4674, 3C58_44D0, then tick -> three consecutive param_we cycles with addr 15, 14, 13 in that order; busy high for exactly 3 cycles.
3. Overflow and collision:
   - 9 writes with no tick -> pending=8, overflow=1, the first 8 entries are applied after tick.
   - trig=16'h0006 -> addr 1 is queued, collision=1.
   - clear_err -> both flags 0.
4. Snapshot boundary: 2 queued, tick, then push a new entry during APPLY -> exactly 2 writes and applied; pending=1; the next tick applies the third.
5. Reset mid-APPLY: 4 queued, tick, assert reset after the 2nd param_we -> param_we=0 asynchronously, pending=0, no applied pulse. A subsequent tick produces no writes.
6. Tick with an empty FIFO, and tick in the same cycle as the first push -> no param_we, state stays IDLE, the pushed entry remains pending=1.

Source files
------------

// File: rtl/param_update_sequencer.sv
// param_update_sequencer
//
// Buffers host parameter writes (trigger vector + 32-bit word) in a small
// FIFO. It applies them to the parameter bank only at a simulation-tick
// boundary, one entry per clock. This keeps the spindle, MN pool and muscle
// datapaths from seeing a parameter change in the middle of a step.
//
// Handshake: the host side has no back-pressure. Any cycle with trig != 0 is
// a write offer. The offer is accepted when the FIFO has room, or when an
// entry leaves in that same cycle. Otherwise it is dropped and overflow is
// flagged. The bank side is a plain write strobe: param_we is high for
// exactly one cycle per entry, and param_addr/param_data are valid with it.
//
// Ports:
//   clk        system clock (clk1 domain)
//   reset      asynchronous active-high reset, clears all state
//   trig       host trigger vector, one-cycle pulses; the lowest set bit selects
//              the parameter
//   wr_data    value to write, valid while trig != 0
//   tick       one-cycle strobe at the start of a simulation step
//   clear_err  synchronous clear of overflow/collision (an event in the same
//              cycle wins)
//   param_we   parameter-bank write strobe
//   param_addr parameter index (holds when param_we = 0)
//   param_data parameter value (holds when param_we = 0)
//   pending    FIFO occupancy, 0..DEPTH
//   busy       high while the batch is being applied
//   applied    one-cycle pulse after a batch completes
//   overflow   sticky: a write was dropped because the FIFO was full
//   collision  sticky: more than one trig bit was set in one cycle
//   state_dbg  current FSM state (0 IDLE, 1 APPLY, 2 DONE)
module param_update_sequencer #(
  parameter int DEPTH      = 8,
  parameter int NUM_PARAMS = 16,
  parameter int ADDR_W     = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PARAMS-1:0] trig,
  input  logic [31:0]           wr_data,
  input  logic                  tick,
  input  logic                  clear_err,
  output logic                  param_we,
  output logic [ADDR_W-1:0]     param_addr,
  output logic [31:0]           param_data,
  output logic [CNT_W-1:0]      pending,
  output logic                  busy,
  output logic                  applied,
  output logic                  overflow,
  output logic                  collision,
  output logic [1:0]            state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   mem_addr [DEPTH];
  logic [31:0]         mem_data [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  // Entries of the current batch still to be popped after this cycle's pop.
  logic [CNT_W-1:0]    remaining;

  logic [ADDR_W-1:0]   cap_idx;
  logic                cap_valid;
  logic                multi_hit;
  logic                fifo_full;
  logic                start;
  logic                pop;
  logic                push;
  logic                drop;

  // Lowest set trigger bit wins; higher bits in the same cycle are dropped.
  always_comb begin
    cap_idx = '0;
    for (int i = NUM_PARAMS - 1; i >= 0; i--) begin
      if (trig[i]) cap_idx = ADDR_W'(i);
    end
  end

  assign cap_valid = |trig;
  // x & (x-1) clears the lowest set bit; anything left means a second bit.
  assign multi_hit = |(trig & (trig - NUM_PARAMS'(1)));
  assign fifo_full = (count == CNT_W'(DEPTH));

  // The first entry of a batch leaves on the tick edge itself, so param_we
  // appears in the first cycle after the tick.
  assign start = (state == S_IDLE) && tick && (count != '0);
  assign pop   = start || ((state == S_APPLY) && (remaining != '0));
  // A full FIFO still accepts a push when an entry leaves in the same cycle.
  assign push  = cap_valid && (!fifo_full || pop);
  assign drop  = cap_valid && fifo_full && !pop;

  assign busy      = (state == S_APPLY);
  assign pending   = count;
  assign state_dbg = state;

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= cap_idx;
      mem_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      remaining  <= '0;
      param_we   <= 1'b0;
      param_addr <= '0;
      param_data <= '0;
      applied    <= 1'b0;
      overflow   <= 1'b0;
      collision  <= 1'b0;
    end else begin
      param_we <= 1'b0;
      applied  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            // The batch is the occupancy before this cycle's push, minus
            // the entry popped right now.
            remaining <= count - CNT_W'(1);
            state     <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
          end else begin
            state   <= S_DONE;
            applied <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (pop) begin
        param_we   <= 1'b1;
        param_addr <= mem_addr[rd_ptr];
        param_data <= mem_data[rd_ptr];
        rd_ptr     <= rd_ptr + PTR_W'(1);
      end

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      count <= count + CNT_W'(push) - CNT_W'(pop);

      overflow  <= (overflow  & ~clear_err) | drop;
      collision <= (collision & ~clear_err) | (cap_valid & multi_hit);
    end
  end

endmodule

// File: tb/tb_param_update_sequencer.sv
module tb_param_update_sequencer;

  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] trig;
  logic [31:0] wr_data;
  logic        tick;
  logic        clear_err;
  logic        param_we;
  logic [3:0]  param_addr;
  logic [31:0] param_data;
  logic [3:0]  pending;
  logic        busy;
  logic        applied;
  logic        overflow;
  logic        collision;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  param_update_sequencer #(
    .DEPTH(8), .NUM_PARAMS(16), .ADDR_W(4), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .trig(trig), .wr_data(wr_data), .tick(tick),
    .clear_err(clear_err), .param_we(param_we), .param_addr(param_addr),
    .param_data(param_data), .pending(pending), .busy(busy),
    .applied(applied), .overflow(overflow), .collision(collision),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  logic [35:0] exp_q[$];   // {addr, data} expected on param_we, in order
  logic [35:0] mq[$];      // entries queued but not yet in a batch
  int          m_inflight; // batch entries still sitting in the DUT FIFO
  int          m_left;     // edges until the sequencer is idle again
  bit          m_ovf;
  bit          m_col;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mq.delete();
    m_inflight = 0;
    m_left     = 0;
    m_ovf      = 0;
    m_col      = 0;
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, advance the model across the coming edge,
  // then check every output just after that edge.
  task automatic cycle(input logic [15:0] t, input logic [31:0] d, input bit tk, input bit ce);
    int  occ;
    bit  pop;
    int  n;
    logic [3:0] idx;
    bit  ev_ovf;
    bit  ev_col;
    logic [35:0] e;
    trig = t; wr_data = d; tick = tk; clear_err = ce;

    occ = mq.size() + m_inflight;
    pop = 0;
    if (m_left == 0) begin
      if (tk && mq.size() != 0) begin
        n = mq.size();
        while (mq.size() != 0) exp_q.push_back(mq.pop_front());
        m_inflight = n - 1;
        m_left     = n + 1;
        pop        = 1;
      end
    end else begin
      if (m_inflight > 0) begin
        pop = 1;
        m_inflight--;
      end
      m_left--;
    end

    ev_ovf = 0;
    ev_col = 0;
    if (t != 16'h0) begin
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) if (t[i]) idx = 4'(i);
      ev_col = ($countones(t) > 1);
      if (occ < DEPTH || pop) mq.push_back({idx, d});
      else ev_ovf = 1;
    end
    m_ovf = (m_ovf && !ce) || ev_ovf;
    m_col = (m_col && !ce) || ev_col;

    @(posedge clk);
    #1;
    chk("busy", busy, m_left >= 2);
    chk("applied", applied, m_left == 1);
    chk("param_we", param_we, m_left >= 2);
    chk("pending", pending, mq.size() + m_inflight);
    chk("overflow", overflow, m_ovf);
    chk("collision", collision, m_col);
    if (param_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {param_addr, param_data}, 36'h0);
      end else begin
        e = exp_q.pop_front();
        chk("param_addr", param_addr, e[35:32]);
        chk("param_data", param_data, e[31:0]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(16'h0, 32'h0, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] trig;
    logic [31:0] data;
    logic [3:0]  exp_addr;
    bit          exp_col;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int busy_cnt;
    int app_cnt;

    vecs[0] = '{16'h0008, 32'h42A0_0000, 4'd3,  1'b0};
    vecs[1] = '{16'h8000, 32'h3E71_4120, 4'd15, 1'b0};
    vecs[2] = '{16'h0001, 32'h0000_0001, 4'd0,  1'b0};
    vecs[3] = '{16'h0006, 32'hDEAD_BEEF, 4'd1,  1'b1};
    vecs[4] = '{16'hFFFF, 32'hFFFF_FFFF, 4'd0,  1'b1};
    vecs[5] = '{16'h0300, 32'h1234_5678, 4'd8,  1'b1};
    vecs[6] = '{16'h0400, 32'hCAFE_F00D, 4'd10, 1'b0};
    vecs[7] = '{16'h8001, 32'h0BAD_0001, 4'd0,  1'b1};

    model_reset();
    trig = '0; wr_data = '0; tick = 0; clear_err = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", param_we, 0);
    chk("rst_addr", param_addr, 0);
    chk("rst_data", param_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_applied", applied, 0);
    chk("rst_flags", {overflow, collision}, 0);
    chk("rst_state", state_dbg, 0);
    reset = 1'b0;
    idle(2);

    // Table: capture, lowest-bit index, collision, then apply on a tick.
    foreach (vecs[k]) begin
      cycle(vecs[k].trig, vecs[k].data, 0, 0);
      chk("tbl_collision", collision, vecs[k].exp_col);
      cycle(16'h0, 32'h0, 1, 1);
      chk("tbl_addr", param_addr, vecs[k].exp_addr);
      chk("tbl_data", param_data, vecs[k].data);
      idle(2);
    end

    // 1: single write, tick 5 cycles later.
    cycle(16'h0008, 32'h42A0_0000, 0, 0);
    idle(4);
    cycle(16'h0, 32'h0, 1, 0);
    chk("t1_we", param_we, 1);
    chk("t1_addr", param_addr, 4'd3);
    idle(1);
    chk("t1_applied", applied, 1);
    idle(1);
    chk("t1_pending", pending, 0);

    // 2: batch ordering, busy exactly 3 cycles.
    cycle(16'h8000, 32'h3E71_4120, 0, 0);
    cycle(16'h4000, 32'h3D14_4674, 0, 0);
    cycle(16'h2000, 32'h3C58_44D0, 0, 0);
    cycle(16'h0, 32'h0, 1, 0);
    busy_cnt = int'(busy);
    for (int i = 0; i < 5; i++) begin
      cycle(16'h0, 32'h0, 0, 0);
      busy_cnt += int'(busy);
    end
    chk("t2_busy_cycles", busy_cnt, 3);

    // 3: overflow, collision, clear; then a set-wins clear.
    for (int i = 0; i < 9; i++) cycle(16'h0001 << i, 32'h1000_0000 + i, 0, 0);
    chk("t3_pending", pending, 8);
    chk("t3_overflow", overflow, 1);
    cycle(16'h0, 32'h0, 1, 0);
    idle(9);
    cycle(16'h0006, 32'h5555_AAAA, 0, 0);
    chk("t3_collision", collision, 1);
    cycle(16'h0, 32'h0, 0, 1);
    chk("t3_cleared", {overflow, collision}, 2'b00);
    cycle(16'h0003, 32'h7777_0000, 0, 1);
    chk("t3_set_wins", collision, 1);
    cycle(16'h0, 32'h0, 1, 1);
    idle(3);

    // 4: snapshot boundary, push during APPLY, tick during APPLY ignored.
    cycle(16'h0010, 32'hA000_0001, 0, 0);
    cycle(16'h0020, 32'hA000_0002, 0, 0);
    cycle(16'h0, 32'h0, 1, 0);
    cycle(16'h0040, 32'hA000_0003, 1, 0);
    idle(2);
    chk("t4_pending", pending, 1);
    cycle(16'h0, 32'h0, 1, 0);
    chk("t4_third_addr", param_addr, 4'd6);
    idle(2);

    // 5: reset in the middle of APPLY.
    for (int i = 0; i < 4; i++) cycle(16'h0100 << i, 32'hB000_0000 + i, 0, 0);
    cycle(16'h0, 32'h0, 1, 0);
    cycle(16'h0, 32'h0, 0, 0);
    chk("t5_second_we", param_we, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_we", param_we, 0);
    chk("t5_pending", pending, 0);
    chk("t5_busy", busy, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    app_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(16'h0, 32'h0, (i == 1), 0);
      app_cnt += int'(applied);
    end
    chk("t5_no_applied", app_cnt, 0);

    // 6: empty tick, and tick coinciding with the first push.
    cycle(16'h0, 32'h0, 1, 0);
    cycle(16'h0002, 32'hC0DE_0002, 1, 0);
    chk("t6_pending", pending, 1);
    chk("t6_state", state_dbg, 0);
    cycle(16'h0, 32'h0, 1, 0);
    idle(2);

    // Random traffic, including full-with-pop and ticks during APPLY.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0, $urandom,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end
    cycle(16'h0, 32'h0, 1, 0);
    idle(12);
    chk("drain_exp_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
